// File: rtl/grande_risco5_fetch_unit.sv
// Decoupled instruction-fetch stage: PC generator, valid/ready imem port and a
// DEPTH-entry prefetch FIFO of (instruction, PC) pairs with redirect flush.
module grande_risco5_fetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [31:0]                  imem_req_address,
  input  logic                         imem_rsp_valid,
  input  logic [31:0]                  imem_rsp_data,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_address,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr_data,
  output logic [31:0]                  instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          active_q, active_d;

  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic credit_ok;
  logic req_accept;
  logic rsp_drop;
  logic rsp_push;
  logic pop;

  // Credit covers buffered plus in-flight fetches, so a push never finds the FIFO full.
  assign credit_ok        = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W;
  assign imem_req_valid   = active_q && !redirect && credit_ok;
  assign imem_req_address = fetch_pc_q;
  assign req_accept       = imem_req_valid && imem_req_ready;
  assign rsp_drop         = imem_rsp_valid && (drop_q != '0);
  assign rsp_push         = imem_rsp_valid && (drop_q == '0) && (outstanding_q != '0);
  assign instr_valid      = (count_q != '0);
  assign pop              = instr_valid && instr_ready && !redirect;
  assign instr_data       = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign instr_pc         = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign occupancy        = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    active_d      = 1'b1;
    if (redirect) begin
      fetch_pc_d    = {redirect_address[31:2], 2'b00};
      rsp_pc_d      = {redirect_address[31:2], 2'b00};
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      outstanding_d = '0;
      // A response landing this cycle retires one stale fetch, dropped or not.
      drop_d        = drop_q + outstanding_q - CW'(rsp_drop || rsp_push);
    end else begin
      if (req_accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rsp_drop) drop_d = drop_q - CW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d       = count_q + CW'(rsp_push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(req_accept) - CW'(rsp_push);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= BOOT_ADDRESS;
      rsp_pc_q      <= BOOT_ADDRESS;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      active_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      active_q      <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!redirect && rsp_push) begin
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_grande_risco5_fetch_unit.sv
// Directed bench for the fetch unit: table of per-cycle vectors plus
// hand-written redirect, stall and asynchronous-reset sequences.
module tb_grande_risco5_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_address;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_address;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  occupancy;

  grande_risco5_fetch_unit #(.BOOT_ADDRESS(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_address(imem_req_address),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_address(redirect_address),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  typedef struct {
    bit          rst;
    bit          rr;
    bit          ir;
    bit          ev;
    logic [31:0] ea;
    bit          eiv;
    logic [31:0] epc;
    int unsigned eocc;
  } vec_t;

  req_t        q[$];
  int unsigned cyc;
  int unsigned lat = 1;
  int unsigned acc_cnt = 0;
  logic [31:0] last_acc = '0;
  int unsigned total = 0;
  int unsigned passed = 0;
  vec_t        tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock; the memory model answers each accepted request lat cycles later.
  task automatic step();
    req_t r;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_address;
      r.due  = cyc + lat;
      q.push_back(r);
      acc_cnt++;
      last_acc = imem_req_address;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~q[0].addr;
      q.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    redirect         = 1'b0;
    redirect_address = '0;
    imem_req_ready   = 1'b1;
    instr_ready      = 1'b1;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = '0;
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic set_vec(input int idx, input bit rst, input bit rr, input bit ir, input bit ev,
                         input logic [31:0] ea, input bit eiv, input logic [31:0] epc,
                         input int unsigned eocc);
    tbl[idx].rst = rst; tbl[idx].rr = rr; tbl[idx].ir = ir; tbl[idx].ev = ev;
    tbl[idx].ea = ea; tbl[idx].eiv = eiv; tbl[idx].epc = epc; tbl[idx].eocc = eocc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    int unsigned a0;

    // Steady state, 1-cycle memory, decode always ready
    set_vec(0,  1, 1, 1, 1, 32'h00, 0, 32'h00, 0);
    set_vec(1,  0, 1, 1, 1, 32'h04, 0, 32'h00, 0);
    set_vec(2,  0, 1, 1, 1, 32'h08, 1, 32'h00, 1);
    set_vec(3,  0, 1, 1, 1, 32'h0C, 1, 32'h04, 1);
    set_vec(4,  0, 1, 1, 1, 32'h10, 1, 32'h08, 1);
    set_vec(5,  0, 1, 1, 1, 32'h14, 1, 32'h0C, 1);
    // Decode stalled: FIFO fills to DEPTH, then drains in order
    set_vec(6,  1, 1, 0, 1, 32'h00, 0, 32'h00, 0);
    set_vec(7,  0, 1, 0, 1, 32'h04, 0, 32'h00, 0);
    set_vec(8,  0, 1, 0, 1, 32'h08, 1, 32'h00, 1);
    set_vec(9,  0, 1, 0, 1, 32'h0C, 1, 32'h00, 2);
    set_vec(10, 0, 1, 0, 0, 32'h10, 1, 32'h00, 3);
    set_vec(11, 0, 1, 0, 0, 32'h10, 1, 32'h00, 4);
    set_vec(12, 0, 1, 0, 0, 32'h10, 1, 32'h00, 4);
    set_vec(13, 0, 1, 1, 1, 32'h10, 1, 32'h04, 3);
    set_vec(14, 0, 1, 1, 1, 32'h14, 1, 32'h08, 2);
    set_vec(15, 0, 1, 1, 1, 32'h18, 1, 32'h0C, 2);
    set_vec(16, 0, 1, 1, 1, 32'h1C, 1, 32'h10, 2);

    // Reset state while reset is held
    reset = 1'b0; redirect = 1'b0; redirect_address = '0;
    imem_req_ready = 1'b1; instr_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #3;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_address, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_occupancy", {29'b0, occupancy}, 32'd0);

    lat = 1;
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) do_reset();
      imem_req_ready = tbl[i].rr;
      instr_ready    = tbl[i].ir;
      step();
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("v%0d_req_addr", i), imem_req_address, tbl[i].ea);
      chk($sformatf("v%0d_instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].eiv});
      chk($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].eiv ? tbl[i].epc : 32'h0);
      chk($sformatf("v%0d_instr_data", i), instr_data, tbl[i].eiv ? ~tbl[i].epc : 32'h0);
      chk($sformatf("v%0d_occupancy", i), {29'b0, occupancy}, tbl[i].eocc);
    end

    // Memory not ready: address held, accepted exactly once when ready returns
    do_reset();
    lat = 1;
    step(); step(); step();
    chk("stall_pre_addr", imem_req_address, 32'h8);
    imem_req_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d_addr", i), imem_req_address, 32'h8);
      chk($sformatf("stall%0d_valid", i), {31'b0, imem_req_valid}, 32'd1);
    end
    chk("stall_no_accept", acc_cnt, a0);
    imem_req_ready = 1'b1;
    step();
    chk("stall_accept_once", acc_cnt, a0 + 1);
    chk("stall_accepted_addr", last_acc, 32'h8);
    chk("stall_next_addr", imem_req_address, 32'hC);

    // 3-cycle memory, two in flight, redirect to 0x100
    do_reset();
    lat = 3;
    step(); step(); step();
    chk("redir_pre_addr", imem_req_address, 32'h8);
    redirect = 1'b1; redirect_address = 32'h100;
    #1;
    chk("redir_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("redir_next_iv", {31'b0, instr_valid}, 32'd0);
    chk("redir_next_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_next_addr", imem_req_address, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    chk("redir_delivered", {31'b0, found}, 32'd1);
    chk("redir_first_pc", instr_pc, 32'h100);
    chk("redir_first_data", instr_data, ~32'h100);

    // Redirect to unaligned address coinciding with a response and a pop
    do_reset();
    lat = 1;
    step(); step(); step(); step();
    chk("coinc_pre_iv", {31'b0, instr_valid}, 32'd1);
    chk("coinc_pre_rsp", {31'b0, imem_rsp_valid}, 32'd1);
    redirect = 1'b1; redirect_address = 32'h102;
    step();
    redirect = 1'b0;
    #1;
    chk("coinc_iv", {31'b0, instr_valid}, 32'd0);
    chk("coinc_occ", {29'b0, occupancy}, 32'd0);
    chk("coinc_addr", imem_req_address, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    chk("coinc_delivered", {31'b0, found}, 32'd1);
    chk("coinc_first_pc", instr_pc, 32'h100);
    chk("coinc_first_data", instr_data, ~32'h100);

    // Asynchronous reset with three entries buffered
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("arst_pre_occ", {29'b0, occupancy}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_iv", {31'b0, instr_valid}, 32'd0);
    chk("arst_occ", {29'b0, occupancy}, 32'd0);
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_req_addr", imem_req_address, 32'h0);
    q.delete();
    imem_rsp_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    step();
    chk("arst_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("arst_restart_addr", imem_req_address, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
